multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Moore FSM that sequences the shared multicycle MIPS datapath (one memory, one ALU): fetch, decode,
//  execute, memory, writeback. Replaces the single-cycle combinational control unit.
//  Supports add/sub/and/or/slt/sll, addi/andi/ori, lw/sw, beq and j.
//  Handshakes with memory via mem_ready, counts retired instructions and halts on illegal ops or memory timeout.
// PARAMETERS
//  CNT_W        32  width of instr_count
//  MEM_TIMEOUT  16  max wait cycles for mem_ready per access; 0 disables the watchdog
// PORTS
//  clk          in   1      clock, all state changes on posedge
//  reset        in   1      synchronous, active-high
//  opcode       in   6      IR[31:26]; stable from DECODE to end of instruction
//  funct        in   6      IR[5:0]
//  zero         in   1      ALU zero flag
//  mem_ready    in   1      memory access completes this cycle (may be combinational)
//  iord         out  1      0: address=PC, 1: address=ALUOut
//  mem_read     out  1      memory read strobe
//  mem_write    out  1      memory write strobe
//  ir_write     out  1      load IR
//  pc_en        out  1      PC load = pc_write | (branch & zero)
//  pc_src       out  2      00 ALU result, 01 ALUOut, 10 jump target
//  reg_write    out  1      register file write
//  reg_dst      out  1      1: rd, 0: rt
//  mem_to_reg   out  1      1: MDR, 0: ALUOut
//  alu_src_a    out  2      00 PC, 01 A, 10 shamt
//  alu_src_b    out  2      00 B, 01 const 4, 10 ext imm, 11 sext imm<<2
//  ext_sel      out  1      1 sign-extend, 0 zero-extend
//  alu_op       out  4      0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 SLL
//  state        out  4      current state, debug only
//  halted       out  1      sticky; set in HALT
//  err_code     out  2      00 none, 01 illegal opcode/funct, 10 memory timeout
//  instr_count  out  CNT_W  retired instructions
// BEHAVIOUR
//  Reset: state=FETCH, instr_count=0, halted=0, err_code=0, wait counter=0. While reset is high, all strobes are forced 0.
//  Outputs not listed for a state are 0. State encodings are given in brackets.
//  FETCH[0]: mem_read=1, iord=0, src_a=00, src_b=01, ADD, pc_src=00. ir_write and pc_write are asserted only when mem_ready=1.
//   mem_ready=1 -> DECODE; otherwise hold.
//  DECODE[1]: src_a=00, src_b=11, ext_sel=1, ADD (branch target into ALUOut). Next state by opcode:
//   0x00 -> EXEC_R; 0x08/0x0C/0x0D -> EXEC_I; 0x23/0x2B -> MEMADR; 0x04 -> BRANCH; 0x02 -> JUMP; else HALT with err=01.
//  MEMADR[2]: src_a=01, src_b=10, ext_sel=1, ADD. lw -> MEMRD, sw -> MEMWR.
//  MEMRD[3]: iord=1, mem_read=1; stays until mem_ready -> MEMWB.
//  MEMWB[4]: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
//  MEMWR[5]: iord=1, mem_write=1; stays until mem_ready -> FETCH.
//  EXEC_R[6]: src_b=00. src_a=10 for sll (funct 0x00), else 01.
//   alu_op by funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x00 SLL.
//   Any other funct -> HALT with err=01; otherwise -> ALUWB.
//  EXEC_I[7]: src_a=01, src_b=10. addi: ADD, ext_sel=1; andi: AND, ext_sel=0; ori: OR, ext_sel=0. -> ALUWB.
//  ALUWB[8]: reg_write=1, mem_to_reg=0, reg_dst=(opcode==0) -> FETCH.
//  BRANCH[9]: src_a=01, src_b=00, SUB, branch=1, pc_src=01 -> FETCH. pc_en follows zero in the same cycle.
//  JUMP[10]: pc_write=1, pc_src=10 -> FETCH.
//  HALT[11]: all strobes 0, halted=1; leaves only on reset.
//  Watchdog: counter clears on entry to FETCH, MEMRD or MEMWR and increments each cycle waiting with mem_ready=0.
//   If MEM_TIMEOUT != 0 and the count reaches MEM_TIMEOUT -> HALT with err=10.
//   mem_ready in that same cycle wins: no timeout.
//  instr_count: +1 on each transition to FETCH from MEMWB, MEMWR, ALUWB, BRANCH or JUMP.
//   Wraps modulo 2^CNT_W. Never increments on entry to HALT.
//  Reset mid-instruction: abort, no strobe in the reset cycle; FETCH on the following cycle.
//  err_code is written once on entry to HALT and holds until reset.
// TESTING
//  1. add (op 0x00, funct 0x20), mem_ready=1 always -> states 0,1,6,8,0.
//     reg_dst=1 in ALUWB; 4 cycles; instr_count=1.
//  2. lw (0x23), mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, mem_read high throughout, mem_to_reg=1 in MEMWB.
//  3. beq (0x04), zero=1 -> pc_en=1, pc_src=01 in BRANCH. With zero=0 -> pc_en=0. Both return to FETCH.
//  4. opcode 0x3F -> DECODE then HALT; halted=1, err_code=01; held 10 cycles with no strobes; reset -> FETCH, count=0.
//  5. MEM_TIMEOUT=4, mem_ready=0 in FETCH -> HALT after 4 waiting cycles, err_code=10.
//     Repeat with mem_ready=1 on the 4th cycle -> DECODE.
//  6. CNT_W=2: run 5 ori (0x0D) instructions -> ext_sel=0, alu_op=0001; instr_count 1,2,3,0,1.

Source files
------------

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control bus between the multicycle controller and its datapath
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_sel;
  logic [3:0] alu_op;
  modport master (
    input  opcode, funct, zero, mem_ready,
    output iord, mem_read, mem_write, ir_write, pc_en, pc_src, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, ext_sel, alu_op
  );
  modport slave (
    output opcode, funct, zero, mem_ready,
    input  iord, mem_read, mem_write, ir_write, pc_en, pc_src, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, ext_sel, alu_op
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing a shared-memory multicycle MIPS datapath
module multicycle_control #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_control_if.master bus,
  output logic [3:0]          state,
  output logic                halted,
  output logic [1:0]          err_code,
  output logic [CNT_W-1:0]    instr_count
);
  localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1, S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
                         S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5, S_EXEC_R = 4'd6,  S_EXEC_I = 4'd7,
                         S_ALUWB  = 4'd8,  S_BRANCH = 4'd9, S_JUMP   = 4'd10, S_HALT   = 4'd11;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08,
                         OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24,
                         F_OR = 6'h25, F_SLT = 6'h2A;
  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010, A_SUB = 4'b0110,
                         A_SLT = 4'b0111, A_SLL = 4'b1000;
  localparam int WT_W = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WT_W-1:0] WT_LAST = WT_W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

  logic [3:0]       state_d, state_q;
  logic [WT_W-1:0]  wait_d, wait_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             halted_d, halted_q;
  logic [1:0]       err_d, err_q;
  logic             r_ok, mem_wait, timeout, retire, pc_write, branch;
  logic [3:0]       r_op;

  always_comb begin
    r_ok = bus.funct inside {F_SLL, F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    r_op = bus.funct == F_ADD ? A_ADD : bus.funct == F_SUB ? A_SUB :
           bus.funct == F_OR  ? A_OR  : bus.funct == F_SLT ? A_SLT :
           bus.funct == F_SLL ? A_SLL : A_AND;
    mem_wait = (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) && !bus.mem_ready;
    timeout  = MEM_TIMEOUT != 0 && mem_wait && wait_q == WT_LAST;
    state_d  = state_q;
    case (state_q)
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = bus.opcode == OP_R ? S_EXEC_R :
                          bus.opcode inside {OP_ADDI, OP_ANDI, OP_ORI} ? S_EXEC_I :
                          bus.opcode inside {OP_LW, OP_SW} ? S_MEMADR :
                          bus.opcode == OP_BEQ ? S_BRANCH :
                          bus.opcode == OP_J ? S_JUMP : S_HALT;
      S_MEMADR: state_d = bus.opcode == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC_R: state_d = r_ok ? S_ALUWB : S_HALT;
      S_EXEC_I: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
    if (timeout) state_d = S_HALT;
    retire   = state_d == S_FETCH && state_q inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP};
    cnt_d    = cnt_q + CNT_W'(retire);
    halted_d = halted_q | (state_d == S_HALT);
    err_d    = state_d == S_HALT && state_q != S_HALT ? (timeout ? 2'b10 : 2'b01) : err_q;
    // any state change restarts the watchdog, so it always measures the current access alone
    wait_d   = state_d != state_q ? '0 : mem_wait ? wait_q + WT_W'(1) : wait_q;
  end

  always_comb begin
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_src     = 2'b00;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.ext_sel    = 1'b0;
    bus.alu_op     = A_AND;
    pc_write       = 1'b0;
    branch         = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.alu_op    = A_ADD;
          bus.ir_write  = bus.mem_ready;
          pc_write      = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_b = 2'b11;
          bus.ext_sel   = 1'b1;
          bus.alu_op    = A_ADD;
        end
        S_MEMADR: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b10;
          bus.ext_sel   = 1'b1;
          bus.alu_op    = A_ADD;
        end
        S_MEMRD: begin
          bus.iord     = 1'b1;
          bus.mem_read = 1'b1;
        end
        S_MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          bus.iord      = 1'b1;
          bus.mem_write = 1'b1;
        end
        S_EXEC_R: begin
          bus.alu_src_a = bus.funct == F_SLL ? 2'b10 : 2'b01;
          bus.alu_op    = r_op;
        end
        S_EXEC_I: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b10;
          bus.ext_sel   = bus.opcode == OP_ADDI;
          bus.alu_op    = bus.opcode == OP_ADDI ? A_ADD : bus.opcode == OP_ANDI ? A_AND : A_OR;
        end
        S_ALUWB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = bus.opcode == OP_R;
        end
        S_BRANCH: begin
          bus.alu_src_a = 2'b01;
          bus.alu_op    = A_SUB;
          bus.pc_src    = 2'b01;
          branch        = 1'b1;
        end
        S_JUMP: begin
          bus.pc_src = 2'b10;
          pc_write   = 1'b1;
        end
        default: ;
      endcase
    end
    bus.pc_en = pc_write | (branch & bus.zero);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      wait_q   <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      err_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign state       = state_q;
  assign halted      = halted_q;
  assign err_code    = err_q;
  assign instr_count = cnt_q;
endmodule
